// File: rtl/fec_pkg.sv
// Shared definitions for the TX FEC chain: frame geometry, convolutional
// code generators and the encoder framing state type.
package fec_pkg;

  // Serial frame length seen by the encoder: payload plus CRC-16.
  localparam int FRAME_BITS_DEF = 1904 + 16;

  // Constraint length of the convolutional code; the tail is K-1 bits.
  localparam int K_DEF = 7;

  // Generator polynomials, MSB applies to the newest bit.
  localparam logic [6:0] G0_DEF = 7'o171;
  localparam logic [6:0] G1_DEF = 7'o133;

  // Framing state of the encoder.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } conv_state_t;

endpackage

// File: rtl/conv_enc_core.sv
// Convolutional encoder datapath: holds the K-1 bit history and produces
// one registered dibit per enabled cycle. A sync clear makes the current
// bit see an all-zero history, so a frame can start without a dead cycle.
module conv_enc_core
  import fec_pkg::*;
#(
  parameter int         K  = K_DEF,
  parameter logic [K-1:0] G0 = G0_DEF,
  parameter logic [K-1:0] G1 = G1_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic       data_bit,
  output logic [1:0] dibit
);

  logic [K-2:0] sr_reg;
  logic [K-2:0] sr_eff;
  logic [K-1:0] win;
  logic [K-1:0] tap0;
  logic [K-1:0] tap1;
  logic [1:0]   dibit_reg;

  // Window seen by the generators: new bit on top, history below it.
  always_comb begin
    sr_eff = clr ? '0 : sr_reg;
    win    = {data_bit, sr_eff};
  end

  // Per-tap generator masking.
  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_tap
      assign tap0[gi] = win[gi] & G0[gi];
      assign tap1[gi] = win[gi] & G1[gi];
    end
  endgenerate

  // Register the parity pair and shift the new bit into the history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_reg    <= '0;
      dibit_reg <= '0;
    end else if (en) begin
      dibit_reg <= {^tap1, ^tap0};
      sr_reg    <= win[K-1:1];
    end
  end

  assign dibit = dibit_reg;

endmodule

// File: rtl/coder_conv.sv
// Rate-1/2 convolutional encoder with frame handling: counts the frame,
// appends the K-1 zero tail, flags framing violations and marks the first
// and last dibit of every frame.
module coder_conv
  import fec_pkg::*;
#(
  parameter int           FRAME_BITS = FRAME_BITS_DEF,
  parameter int           K          = K_DEF,
  parameter logic [K-1:0] G0         = G0_DEF,
  parameter logic [K-1:0] G1         = G1_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ival,
  input  logic       isop,
  input  logic       idat,
  output logic       oreq,
  output logic [1:0] odat,
  output logic       oval,
  output logic       osop,
  output logic       oeop,
  output logic       oerr
);

  localparam int            CW        = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(FRAME_BITS - 1);
  localparam logic [2:0]    TAIL_LAST = 3'(K - 2);

  conv_state_t   state_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    tail_reg;
  logic          oreq_reg;
  logic          oval_reg;
  logic          osop_reg;
  logic          oeop_reg;
  logic          oerr_reg;

  logic start;
  logic enc_en;
  logic enc_clr;
  logic enc_bit;

  // Decide which cycles feed the encoder and with what bit.
  always_comb begin
    start   = ival & isop & (state_reg != TAIL);
    enc_en  = 1'b0;
    enc_clr = start;
    enc_bit = idat;
    case (state_reg)
      IDLE:    enc_en = start;
      DATA:    enc_en = ival;
      TAIL: begin
        enc_en  = 1'b1;
        enc_bit = 1'b0;
      end
      default: enc_en = 1'b0;
    endcase
  end

  conv_enc_core #(
    .K  (K),
    .G0 (G0),
    .G1 (G1)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .en       (enc_en),
    .clr      (enc_clr),
    .data_bit (enc_bit),
    .dibit    (odat)
  );

  // Framing FSM with registered strobes, aligned with the core's dibit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      tail_reg  <= '0;
      oreq_reg  <= 1'b0;
      oval_reg  <= 1'b0;
      osop_reg  <= 1'b0;
      oeop_reg  <= 1'b0;
      oerr_reg  <= 1'b0;
    end else begin
      oval_reg <= enc_en;
      osop_reg <= start;
      oeop_reg <= 1'b0;
      oerr_reg <= 1'b0;
      case (state_reg)
        IDLE, DATA: begin
          if (start) begin
            // A start inside a frame abandons it; restart from bit 0.
            oerr_reg <= (state_reg == DATA);
            cnt_reg  <= CW'(1);
            tail_reg <= '0;
            if (FRAME_BITS == 1) begin
              state_reg <= TAIL;
              oreq_reg  <= 1'b1;
            end else begin
              state_reg <= DATA;
            end
          end else if (ival && state_reg == DATA) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == LAST_CNT) begin
              state_reg <= TAIL;
              oreq_reg  <= 1'b1;
              tail_reg  <= '0;
            end
          end
        end
        TAIL: begin
          // Upstream is held off here; anything it sends is a violation.
          oerr_reg <= ival;
          if (tail_reg == TAIL_LAST) begin
            state_reg <= IDLE;
            oreq_reg  <= 1'b0;
            oeop_reg  <= 1'b1;
            tail_reg  <= '0;
            cnt_reg   <= '0;
          end else begin
            tail_reg <= tail_reg + 3'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign oreq = oreq_reg;
  assign oval = oval_reg;
  assign osop = osop_reg;
  assign oeop = oeop_reg;
  assign oerr = oerr_reg;

endmodule

// File: tb/tb_coder_conv.sv
// Bench for coder_conv: hand-computed table vectors at frame start plus
// whole-frame sequences checked against a convolution model.
`timescale 1ns/1ps
module tb_coder_conv;
  import fec_pkg::*;

  localparam int FB   = FRAME_BITS_DEF;
  localparam int NOUT = FB + K_DEF - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ival = 1'b0;
  logic       isop = 1'b0;
  logic       idat = 1'b0;
  logic       oreq;
  logic [1:0] odat;
  logic       oval;
  logic       osop;
  logic       oeop;
  logic       oerr;

  coder_conv dut (
    .clk  (clk),
    .rst  (rst),
    .ival (ival),
    .isop (isop),
    .idat (idat),
    .oreq (oreq),
    .odat (odat),
    .oval (oval),
    .osop (osop),
    .oeop (oeop),
    .oerr (oerr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [1:0] d;
    logic       sop;
    logic       eop;
  } rec_t;

  typedef struct {
    logic       v;
    logic       s;
    logic       d;
    logic       eo;
    logic [1:0] ed;
  } vec_t;

  vec_t tbl [18];
  rec_t got_q [$];
  rec_t exp_q [$];
  int   oreq_runs [$];
  int   oreq_run = 0;
  int   oerr_cycles = 0;
  logic mon_en = 1'b0;
  logic frame_bits [FB];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock: drive inputs after the edge, return just after the next
  // edge with that cycle's outputs visible, and log them.
  task automatic cyc(input logic v, input logic s, input logic d);
    ival = v;
    isop = s;
    idat = d;
    @(posedge clk);
    #1;
    if (mon_en) begin
      if (oval) got_q.push_back('{d: odat, sop: osop, eop: oeop});
      if (oreq) oreq_run++;
      else if (oreq_run != 0) begin
        oreq_runs.push_back(oreq_run);
        oreq_run = 0;
      end
      if (oerr) oerr_cycles++;
    end
  endtask

  // Expected dibits as a direct convolution of the input with the generators.
  task automatic add_frame(input int nbits, input bit full);
    int   nout;
    logic p0, p1;
    nout = full ? NOUT : nbits;
    for (int t = 0; t < nout; t++) begin
      p0 = 1'b0;
      p1 = 1'b0;
      for (int j = 0; j < K_DEF; j++) begin
        if (t - j >= 0 && t - j < nbits && frame_bits[t - j]) begin
          p0 = p0 ^ G0_DEF[K_DEF - 1 - j];
          p1 = p1 ^ G1_DEF[K_DEF - 1 - j];
        end
      end
      exp_q.push_back('{d: {p1, p0}, sop: (t == 0), eop: (full && t == NOUT - 1)});
    end
  endtask

  task automatic send_bits(input int from, input int upto, input bit gapped, inout int gap_err);
    for (int i = from; i < upto; i++) begin
      if (gapped && $urandom_range(0, 1) == 1) begin
        cyc(1'b0, 1'b0, 1'b0);
        if (oval) gap_err++;
      end
      cyc(1'b1, (i == 0), frame_bits[i]);
      if (!oval) gap_err++;
    end
  endtask

  // Run idle cycles until oeop; optionally push a stray bit on tail cycle n.
  task automatic finish_tail(input string name, input int stray_at);
    int   n;
    logic seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      n++;
      cyc((stray_at == n), 1'b0, (stray_at == n));
      seen = oeop;
    end
    check({name, " oeop seen"}, 32'(seen), 32'd1);
    check({name, " tail cycles"}, n, 6);
  endtask

  task automatic compare_stream(input string name);
    int n, dm, fm;
    dm = 0;
    fm = 0;
    n  = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (got_q[i].d !== exp_q[i].d) dm++;
      if ({got_q[i].sop, got_q[i].eop} !== {exp_q[i].sop, exp_q[i].eop}) fm++;
    end
    $display("frame %s: %0d dibits captured, %0d expected", name, got_q.size(), exp_q.size());
    check({name, " dibit count"}, got_q.size(), exp_q.size());
    check({name, " dibit errors"}, dm, 0);
    check({name, " sop/eop errors"}, fm, 0);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_side(input string name, input int exp_oerr);
    int r;
    r = (oreq_runs.size() > 0) ? oreq_runs[0] : 0;
    check({name, " oreq runs"}, oreq_runs.size(), 1);
    check({name, " oreq length"}, r, 6);
    check({name, " oerr cycles"}, oerr_cycles, exp_oerr);
    oreq_runs.delete();
    oerr_cycles = 0;
  endtask

  task automatic apply_rows(input int lo, input int hi, output int nsent);
    nsent = 0;
    for (int r = lo; r <= hi; r++) begin
      cyc(tbl[r].v, tbl[r].s, tbl[r].d);
      if (tbl[r].v) nsent++;
      check($sformatf("tbl row %0d oval", r), 32'(oval), 32'(tbl[r].eo));
      if (tbl[r].eo) check($sformatf("tbl row %0d odat", r), 32'(odat), 32'(tbl[r].ed));
    end
  endtask

  task automatic rand_bits();
    for (int i = 0; i < FB; i++) frame_bits[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic zero_bits();
    for (int i = 0; i < FB; i++) frame_bits[i] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int ge;
    int ns;

    // Impulse response {odat[1],odat[0]}: 11,01,11,11,00,10,11 then 00.
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b11};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b01};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b11};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b11};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b00};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b10};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b11};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b00};
    // Input 1,1 then zeros, with one idle gap: impulse XOR shifted impulse.
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b11};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b10};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b10};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b00};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b11};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b10};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b01};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b11};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b00};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", 32'({oreq, oval, osop, oeop, oerr, odat}), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Bits without isop in IDLE are dropped silently.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b1);
      check("idle drop oval", 32'(oval), 32'd0);
      check("idle drop oerr", 32'(oerr), 32'd0);
    end
    mon_en = 1'b1;

    // All-zero frame.
    ge = 0;
    zero_bits();
    add_frame(FB, 1'b1);
    send_bits(0, FB, 1'b0, ge);
    finish_tail("zero", 0);
    check("zero oval follow", ge, 0);
    compare_stream("zero");
    check_side("zero", 0);

    // Impulse frame, then a back-to-back frame started right after oeop.
    ge = 0;
    zero_bits();
    frame_bits[0] = 1'b1;
    add_frame(FB, 1'b1);
    apply_rows(0, 7, ns);
    send_bits(ns, FB, 1'b0, ge);
    finish_tail("impulse", 0);
    compare_stream("impulse");
    check_side("impulse", 0);

    zero_bits();
    frame_bits[0] = 1'b1;
    frame_bits[1] = 1'b1;
    add_frame(FB, 1'b1);
    apply_rows(8, 17, ns);
    send_bits(ns, FB, 1'b0, ge);
    finish_tail("pair b2b", 0);
    check("pair b2b oval follow", ge, 0);
    compare_stream("pair b2b");
    check_side("pair b2b", 0);

    // Random frame with ival gaps.
    ge = 0;
    rand_bits();
    add_frame(FB, 1'b1);
    send_bits(0, FB, 1'b1, ge);
    finish_tail("gapped", 0);
    check("gapped oval follow", ge, 0);
    compare_stream("gapped");
    check_side("gapped", 0);

    // Mid-frame isop at bit 700 aborts the first frame.
    ge = 0;
    rand_bits();
    add_frame(700, 1'b0);
    send_bits(0, 700, 1'b0, ge);
    rand_bits();
    add_frame(FB, 1'b1);
    send_bits(0, FB, 1'b0, ge);
    finish_tail("abort", 0);
    check("abort oval follow", ge, 0);
    compare_stream("abort");
    check_side("abort", 1);

    // Stray bit on tail cycle 3 is dropped and flagged.
    ge = 0;
    rand_bits();
    add_frame(FB, 1'b1);
    send_bits(0, FB, 1'b0, ge);
    finish_tail("tail stray", 3);
    compare_stream("tail stray");
    check_side("tail stray", 1);

    // Asynchronous reset in the middle of DATA.
    ge = 0;
    rand_bits();
    send_bits(0, 100, 1'b0, ge);
    check("pre-reset oval", 32'(oval), 32'd1);
    mon_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("async reset outputs", 32'({oreq, oval, osop, oeop, oerr, odat}), 32'd0);
    got_q.delete();
    exp_q.delete();
    oreq_runs.delete();
    oreq_run = 0;
    oerr_cycles = 0;
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, 1'b1);
      check("post-reset needs isop", 32'(oval), 32'd0);
    end
    mon_en = 1'b1;
    rand_bits();
    add_frame(FB, 1'b1);
    send_bits(0, FB, 1'b0, ge);
    finish_tail("after reset", 0);
    compare_stream("after reset");
    check_side("after reset", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/coder_conv.md
Name: coder_conv

Overview:
- Rate-1/2, K=7 convolutional encoder placed directly downstream of the CRC inserter in the TX FEC chain.
- Consumes the serial CRC-protected frame: 1904 payload bits plus 16 CRC bits, 1920 bits total.
- Emits one coded dibit per accepted input bit.
- Appends K-1 zero tail bits so every frame terminates in the all-zero state. The tail is followed by the framing/modulation stage.

Parameters:
- FRAME_BITS, 1920, input bits per frame (payload + CRC).
- K, 7, constraint length; tail length is K-1.
- G0, 7'o171, generator polynomial for odat[0].
- G1, 7'o133, generator polynomial for odat[1].

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- ival  in  1  input bit valid
- isop  in  1  first bit of frame, qualified by ival
- idat  in  1  input bit
- oreq  out  1  hold request to upstream; high during tail insertion
- odat  out  2  coded dibit: [0]=G0 parity, [1]=G1 parity
- oval  out  1  odat valid
- osop  out  1  first dibit of frame
- oeop  out  1  last tail dibit of frame
- oerr  out  1  one-cycle pulse on framing violation

Behaviour:
- Reset values:
  - All outputs 0.
  - Shift register sr[K-2:0] = 0, bit counter = 0, tail counter = 0.
  - State = IDLE.
- Encoding of an accepted bit b:
  - Window w = {b, sr}, where w[6] = b and sr[5] is the most recent previous bit.
  - odat[0] = ^(w & G0); odat[1] = ^(w & G1).
  - Then sr <= {b, sr[5:1]}.
- All outputs are registered. Latency is 1 cycle from the accepted input to oval/odat.
- FSM states:
  - IDLE:
    - ival & isop: clear sr, so the window uses sr = 0. Accept b, set counter = 1, osop = 1, go to DATA.
    - ival without isop: drop the bit. No output and no oerr.
  - DATA:
    - Each ival accepts one bit and increments the counter. Gaps in ival are allowed; oval follows ival with 1-cycle delay.
    - When the accepted bit is bit FRAME_BITS-1 (counter reaches FRAME_BITS), go to TAIL and set oreq=1 on the next cycle.
    - ival & isop mid-frame: pulse oerr, abandon the current frame (no tail, no oeop). Restart as if in IDLE with this bit as bit 0: sr cleared, osop=1.
  - TAIL:
    - K-1 = 6 consecutive cycles. Each cycle encodes b=0 with oval=1.
    - oreq is high for exactly these 6 cycles.
    - oeop=1 coincides with the 6th tail dibit.
    - Then go to IDLE, with oreq=0 on the following cycle.
    - Any ival during TAIL is dropped and pulses oerr. An isop during TAIL is dropped too; there is no restart.
- Frame output is exactly FRAME_BITS+6 = 1926 dibits. osop is on dibit 0; oeop is on dibit 1925.
- After the tail, sr is all-zero by construction, and no explicit clear is needed.
- Counter width is $clog2(FRAME_BITS+1). The tail counter is 3 bits.
- A frame with only one bit (FRAME_BITS=1 configuration) is legal: IDLE goes to DATA and immediately to TAIL.
- Reset mid-frame clears everything asynchronously. No partial tail is emitted, and the next frame needs isop.

Decomposition:
- Shared package fec_pkg:
  - FRAME_BITS_DEF = 1920 and K_DEF = 7.
  - G0_DEF / G1_DEF.
  - State enum conv_state_t {IDLE, DATA, TAIL}.
  - Shared with coder_CRC's frame length, 1904+16.
- One sub-module, conv_enc_core:
  - Holds sr.
  - Inputs are an enable, a sync clear and the bit.
  - Produces the registered dibit.
- The top level holds the FSM, the counters, oreq/osop/oeop/oerr and the framing rules.

Test Plan:
- All-zero frame: 1920 zero bits with continuous ival -> 1926 dibits of 2'b00, osop on the first, oeop on the last, oreq high for 6 cycles, oerr never asserted.
- Impulse: frame with bit0=1 and the rest 0 -> first 7 dibits {odat[1],odat[0]} = 11,01,11,11,00,10,11 (G0=1111001, G1=1011011 MSB-first), then 00 to the end.
- Gapped input: random frame with ival toggling 50% -> dibit stream matches the golden model. oval appears exactly 1 cycle after each accepted ival, and the total count is 1926.
- Back-to-back frames: a new isop on the first cycle after oeop -> accepted, osop correct, new frame starts from zero state and matches the model.
- Mid-frame isop at bit 700 -> oerr 1-cycle pulse, no oeop for the aborted frame, and the new frame encodes from zero state correctly.
- ival during TAIL (cycle 3) plus async reset asserted mid-DATA -> oerr pulse with the bit ignored. The reset drives all outputs to 0 immediately, and a subsequent frame encodes correctly.
